// File: rtl/alu_multiciclo.sv
// alu_multiciclo: registered ALU with a valid/ready issue handshake and a done pulse.
// Logic, ADD and SUB finish in one cycle. Shifts move one bit per cycle.
// MUL is a shift-add loop that handles one multiplier bit per cycle.
// The first step of every iterative op runs on the accept edge, so a
// latency-L operation pulses done_o on edge accept+L-1.
module alu_multiciclo #(
  parameter int unsigned ANCHO = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [ANCHO-1:0] ALUa_i,
  input  logic [ANCHO-1:0] ALUb_i,
  input  logic             ALUflagin_i,
  input  logic [3:0]       ALUcontrol_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [ANCHO-1:0] ALUresult_o,
  output logic [ANCHO-1:0] ALUresulthi_o,
  output logic [3:0]       ALUflags_o,
  output logic             illegal_o
);

  localparam int unsigned CW  = $clog2(ANCHO + 1);
  localparam int unsigned W1  = ANCHO + 1;
  localparam int unsigned MSB = ANCHO - 1;

  localparam logic [ANCHO-1:0] ANCHO_V = ANCHO'(ANCHO);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(ANCHO);
  localparam logic [CW-1:0]    CNT_MUL = CW'(ANCHO - 1);

  localparam logic [3:0] OP_AND = 4'b1100;
  localparam logic [3:0] OP_OR  = 4'b1101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [ANCHO-1:0] acc_q, acc_d;       // shift value, or product high half
  logic [ANCHO-1:0] mlo_q, mlo_d;       // multiplier / product low half
  logic [ANCHO-1:0] mcand_q, mcand_d;   // held multiplicand
  logic [CW-1:0]    cnt_q, cnt_d;       // steps still to run after this edge
  logic [ANCHO-1:0] result_q, result_d;
  logic [ANCHO-1:0] resulthi_q, resulthi_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic             idle;
  logic             accept;
  logic             is_shift;
  logic [CW-1:0]    shamt;
  logic [W1-1:0]    add_full;
  logic [W1-1:0]    sub_full;

  logic [ANCHO-1:0] sh_src;
  logic [3:0]       sh_op;
  logic [ANCHO-1:0] sh_val;
  logic             sh_out;

  logic [ANCHO-1:0] mul_a;
  logic [ANCHO-1:0] mul_hi;
  logic [ANCHO-1:0] mul_lo;
  logic [W1-1:0]    mul_sum;
  logic [ANCHO-1:0] mul_nhi;
  logic [ANCHO-1:0] mul_nlo;

  logic             fin;
  logic [ANCHO-1:0] fin_res;
  logic [ANCHO-1:0] fin_hi;
  logic             fin_c;
  logic             fin_v;
  logic             fin_ill;

  assign idle     = (state_q == S_IDLE);
  assign ready_o  = idle & ~rst_i;
  assign accept   = valid_i & ready_o;
  assign is_shift = (ALUcontrol_i == OP_SLL) || (ALUcontrol_i == OP_SRL) ||
                    (ALUcontrol_i == OP_SRA);
  assign shamt    = (ALUb_i >= ANCHO_V) ? CNT_MAX : CW'(ALUb_i);

  // One-cycle adder/subtractor with carry/borrow in the extra top bit
  assign add_full = {1'b0, ALUa_i} + {1'b0, ALUb_i} + W1'(ALUflagin_i);
  assign sub_full = {1'b0, ALUa_i} - {1'b0, ALUb_i} - W1'(ALUflagin_i);

  // Single-bit shift step; sources come from the ports on the accept edge
  always_comb begin
    sh_src = idle ? ALUa_i : acc_q;
    sh_op  = idle ? ALUcontrol_i : op_q;
    sh_val = sh_src;
    sh_out = 1'b0;
    case (sh_op)
      OP_SLL: begin
        sh_val = {sh_src[ANCHO-2:0], 1'b0};
        sh_out = sh_src[MSB];
      end
      OP_SRL: begin
        sh_val = {1'b0, sh_src[ANCHO-1:1]};
        sh_out = sh_src[0];
      end
      OP_SRA: begin
        sh_val = {sh_src[MSB], sh_src[ANCHO-1:1]};
        sh_out = sh_src[0];
      end
      default: begin
        sh_val = sh_src;
        sh_out = 1'b0;
      end
    endcase
  end

  // Shift-add multiply step: conditionally add the multiplicand, then shift right
  assign mul_a   = idle ? ALUa_i : mcand_q;
  assign mul_hi  = idle ? '0 : acc_q;
  assign mul_lo  = idle ? ALUb_i : mlo_q;
  assign mul_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : W1'(0));
  assign mul_nhi = mul_sum[ANCHO:1];
  assign mul_nlo = {mul_sum[0], mul_lo[ANCHO-1:1]};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_shift && (shamt > CNT_ONE)) begin
            state_d = S_SHIFT;
          end else if (ALUcontrol_i == OP_MUL) begin
            state_d = S_MUL;
          end
        end
      end
      S_SHIFT, S_MUL: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; fin marks the edge that retires an op
  always_comb begin
    op_d    = op_q;
    acc_d   = acc_q;
    mlo_d   = mlo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    fin_res = '0;
    fin_hi  = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_ill = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (ALUcontrol_i)
            OP_AND: begin
              fin     = 1'b1;
              fin_res = ALUa_i & ALUb_i;
            end
            OP_OR: begin
              fin     = 1'b1;
              fin_res = ALUa_i | ALUb_i;
            end
            OP_XOR: begin
              fin     = 1'b1;
              fin_res = ALUa_i ^ ALUb_i;
            end
            OP_ADD: begin
              fin     = 1'b1;
              fin_res = add_full[ANCHO-1:0];
              fin_c   = add_full[ANCHO];
              fin_v   = (ALUa_i[MSB] == ALUb_i[MSB]) && (fin_res[MSB] != ALUa_i[MSB]);
            end
            OP_SUB: begin
              fin     = 1'b1;
              fin_res = sub_full[ANCHO-1:0];
              fin_c   = sub_full[ANCHO];
              fin_v   = (ALUa_i[MSB] != ALUb_i[MSB]) && (fin_res[MSB] != ALUa_i[MSB]);
            end
            OP_SLL, OP_SRL, OP_SRA: begin
              op_d  = ALUcontrol_i;
              acc_d = sh_val;
              if (shamt == '0) begin
                fin     = 1'b1;
                fin_res = ALUa_i;
              end else begin
                cnt_d = shamt - CNT_ONE;
                if (shamt == CNT_ONE) begin
                  fin     = 1'b1;
                  fin_res = sh_val;
                  fin_c   = sh_out;
                end
              end
            end
            OP_MUL: begin
              mcand_d = ALUa_i;
              acc_d   = mul_nhi;
              mlo_d   = mul_nlo;
              cnt_d   = CNT_MUL;
            end
            default: begin
              fin     = 1'b1;
              fin_ill = 1'b1;
            end
          endcase
        end
      end
      S_SHIFT: begin
        acc_d = sh_val;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          fin     = 1'b1;
          fin_res = sh_val;
          fin_c   = sh_out;
        end
      end
      S_MUL: begin
        acc_d = mul_nhi;
        mlo_d = mul_nlo;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          fin     = 1'b1;
          fin_res = mul_nlo;
          fin_hi  = mul_nhi;
          fin_c   = |mul_nhi;
        end
      end
      default: ;
    endcase

    result_d   = fin ? fin_res : result_q;
    resulthi_d = fin ? fin_hi : resulthi_q;
    flags_d    = fin ? {fin_c, (fin_res == '0), fin_res[MSB], fin_v} : flags_q;
    done_d     = fin;
    illegal_d  = fin_ill;
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q       <= '0;
      acc_q      <= '0;
      mlo_q      <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      resulthi_q <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      acc_q      <= acc_d;
      mlo_q      <= mlo_d;
      mcand_q    <= mcand_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      resulthi_q <= resulthi_d;
      flags_q    <= flags_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  assign done_o        = done_q;
  assign ALUresult_o   = result_q;
  assign ALUresulthi_o = resulthi_q;
  assign ALUflags_o    = flags_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed testbench for alu_multiciclo at ANCHO=16.
module tb_alu_multiciclo;

  localparam int unsigned W = 16;

  localparam logic [3:0] OP_AND = 4'b1100;
  localparam logic [3:0] OP_OR  = 4'b1101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic [W-1:0] ALUa_i;
  logic [W-1:0] ALUb_i;
  logic         ALUflagin_i;
  logic [3:0]   ALUcontrol_i;
  logic         ready_o;
  logic         done_o;
  logic [W-1:0] ALUresult_o;
  logic [W-1:0] ALUresulthi_o;
  logic [3:0]   ALUflags_o;
  logic         illegal_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int acc_cyc  = 0;

  alu_multiciclo #(.ANCHO(W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .ALUa_i        (ALUa_i),
    .ALUb_i        (ALUb_i),
    .ALUflagin_i   (ALUflagin_i),
    .ALUcontrol_i  (ALUcontrol_i),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .ALUresult_o   (ALUresult_o),
    .ALUresulthi_o (ALUresulthi_o),
    .ALUflags_o    (ALUflags_o),
    .illegal_o     (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request for a single edge and note the accept cycle
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic fi);
    ALUcontrol_i = op;
    ALUa_i       = a;
    ALUb_i       = b;
    ALUflagin_i  = fi;
    valid_i      = 1'b1;
    step();
    valid_i      = 1'b0;
    acc_cyc      = cyc_cnt;
  endtask

  // Bounded wait for done_o; latency -1 means it never came
  task automatic wait_done(output int lat);
    int guard = 0;
    while (done_o !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    lat = (done_o === 1'b1) ? (cyc_cnt - acc_cyc + 1) : -1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic fi, input int exp_lat,
                        input logic [W-1:0] exp_res, input logic [W-1:0] exp_hi,
                        input logic [3:0] exp_flags, input logic exp_ill);
    int lat;
    check({tag, " ready"}, 64'(ready_o), 64'(1));
    issue(op, a, b, fi);
    wait_done(lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(ALUresult_o), 64'(exp_res));
    check({tag, " resulthi"}, 64'(ALUresulthi_o), 64'(exp_hi));
    check({tag, " flags"}, 64'(ALUflags_o), 64'(exp_flags));
    check({tag, " illegal"}, 64'(illegal_o), 64'(exp_ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dones;
    rst_i        = 1'b1;
    valid_i      = 1'b0;
    ALUa_i       = '0;
    ALUb_i       = '0;
    ALUflagin_i  = 1'b0;
    ALUcontrol_i = 4'b0000;

    // Power-up reset
    step();
    step();
    check("reset ready", 64'(ready_o), 64'(0));
    check("reset done", 64'(done_o), 64'(0));
    check("reset result", 64'(ALUresult_o), 64'(0));
    check("reset resulthi", 64'(ALUresulthi_o), 64'(0));
    check("reset flags", 64'(ALUflags_o), 64'(0));
    rst_i = 1'b0;
    #1;
    check("post-reset ready", 64'(ready_o), 64'(1));

    // ADD overflow and carry/zero wrap
    run_op("add ovf", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 16'h0, 4'b0011, 1'b0);
    run_op("add wrap", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 16'h0, 4'b1100, 1'b0);

    // SUB with borrow-in immediately followed by AND
    ALUcontrol_i = OP_SUB;
    ALUa_i       = 16'h0003;
    ALUb_i       = 16'h0003;
    ALUflagin_i  = 1'b1;
    valid_i      = 1'b1;
    step();
    check("sub done", 64'(done_o), 64'(1));
    check("sub result", 64'(ALUresult_o), 64'(16'hFFFF));
    check("sub flags", 64'(ALUflags_o), 64'(4'b1010));
    check("b2b ready", 64'(ready_o), 64'(1));
    ALUcontrol_i = OP_AND;
    ALUa_i       = 16'hF0F0;
    ALUb_i       = 16'h0FF0;
    ALUflagin_i  = 1'b0;
    step();
    valid_i = 1'b0;
    check("and done", 64'(done_o), 64'(1));
    check("and result", 64'(ALUresult_o), 64'(16'h00F0));
    check("and flags", 64'(ALUflags_o), 64'(4'b0000));

    run_op("or", OP_OR, 16'h00F0, 16'h0F00, 1'b0, 1, 16'h0FF0, 16'h0, 4'b0000, 1'b0);
    run_op("xor", OP_XOR, 16'hAAAA, 16'h0FF0, 1'b0, 1, 16'hA55A, 16'h0, 4'b0010, 1'b0);

    // Shifts, including zero amount and clamped amounts
    run_op("sra3", OP_SRA, 16'h8001, 16'd3, 1'b0, 3, 16'hF000, 16'h0, 4'b0010, 1'b0);
    run_op("sra40", OP_SRA, 16'h8001, 16'd40, 1'b0, 16, 16'hFFFF, 16'h0, 4'b1010, 1'b0);
    run_op("sll0", OP_SLL, 16'h1234, 16'd0, 1'b0, 1, 16'h1234, 16'h0, 4'b0000, 1'b0);
    run_op("srl1", OP_SRL, 16'h8001, 16'd1, 1'b0, 1, 16'h4000, 16'h0, 4'b1000, 1'b0);
    run_op("sll20", OP_SLL, 16'h8001, 16'd20, 1'b0, 16, 16'h0000, 16'h0, 4'b1100, 1'b0);

    // MUL with inputs disturbed and a request offered while busy
    check("mul ready", 64'(ready_o), 64'(1));
    issue(OP_MUL, 16'hFFFF, 16'h0002, 1'b0);
    repeat (4) step();
    ALUa_i       = 16'h1234;
    ALUcontrol_i = OP_ADD;
    valid_i      = 1'b1;
    check("mul busy ready", 64'(ready_o), 64'(0));
    repeat (4) step();
    valid_i = 1'b0;
    wait_done(lat);
    check("mul latency", 64'(lat), 64'(16));
    check("mul lo", 64'(ALUresult_o), 64'(16'hFFFE));
    check("mul hi", 64'(ALUresulthi_o), 64'(16'h0001));
    check("mul flags", 64'(ALUflags_o), 64'(4'b1010));
    step();
    check("mul dropped req", 64'(done_o), 64'(0));
    check("mul idle ready", 64'(ready_o), 64'(1));
    step();
    check("mul hold lo", 64'(ALUresult_o), 64'(16'hFFFE));
    check("mul hold hi", 64'(ALUresulthi_o), 64'(16'h0001));

    run_op("mul small", OP_MUL, 16'h0003, 16'h0005, 1'b0, 16, 16'h000F, 16'h0000, 4'b0000, 1'b0);
    run_op("mul mid", OP_MUL, 16'h0123, 16'h0100, 1'b0, 16, 16'h2300, 16'h0001, 4'b1000, 1'b0);

    // Reset in the middle of a MUL aborts it with no done
    issue(OP_MUL, 16'h00FF, 16'h00FF, 1'b0);
    repeat (3) step();
    rst_i = 1'b1;
    step();
    check("abort ready", 64'(ready_o), 64'(0));
    check("abort done", 64'(done_o), 64'(0));
    step();
    check("abort result", 64'(ALUresult_o), 64'(0));
    check("abort resulthi", 64'(ALUresulthi_o), 64'(0));
    check("abort flags", 64'(ALUflags_o), 64'(0));
    rst_i = 1'b0;
    #1;
    check("abort release ready", 64'(ready_o), 64'(1));
    dones = 0;
    repeat (30) begin
      step();
      if (done_o === 1'b1) dones++;
    end
    check("abort no done", 64'(dones), 64'(0));

    // Undefined opcodes
    run_op("illegal 0000", 4'b0000, 16'h1234, 16'h5678, 1'b0, 1, 16'h0, 16'h0, 4'b0100, 1'b1);
    run_op("illegal 0101", 4'b0101, 16'hFFFF, 16'hFFFF, 1'b1, 1, 16'h0, 16'h0, 4'b0100, 1'b1);
    step();
    check("illegal pulse", 64'(illegal_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
